// File: rtl/program_loader.sv
// Boot loader: parses an 0xA5-framed, XOR-checksummed byte stream into big-endian
// 16-bit words and writes them to instruction RAM while holding the CPU in reset.
module program_loader #(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_rx_valid,
  input  logic [7:0]            i_rx_data,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [15:0]           o_wr_data,
  output logic                  o_cpu_hold,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = ADDR_WIDTH + 1;
  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_WIDTH;
  localparam logic [7:0]  SYNC    = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [7:0]            hi_q, hi_d;
  logic [7:0]            acc_q, acc_d;
  logic [CW-1:0]         tmo_q, tmo_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]           wr_data_q, wr_data_d;
  logic                  hold_q, hold_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic [15:0]   len_new;
  logic [IW-1:0] idx_inc;
  logic [CW-1:0] tmo_inc;
  logic          fail;

  always_comb begin
    // NOTE: every value written here gets a default first, so no latch is inferred.
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    hi_d      = hi_q;
    acc_d     = acc_q;
    tmo_d     = tmo_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    hold_d    = hold_q;
    done_d    = 1'b0;
    error_d   = error_q;
    fail      = 1'b0;
    len_new   = {len_q[15:8], i_rx_data};
    idx_inc   = idx_q + IW'(1);
    tmo_inc   = tmo_q + CW'(1);

    if (i_rx_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (i_rx_data == SYNC) begin
            state_d = S_LEN_HI;
            hold_d  = 1'b1;
            error_d = 1'b0;
            acc_d   = '0;
            idx_d   = '0;
          end
        end
        S_LEN_HI: begin
          len_d   = {i_rx_data, 8'h00};
          acc_d   = acc_q ^ i_rx_data;
          state_d = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d = len_new;
          acc_d = acc_q ^ i_rx_data;
          if ({1'b0, len_new} > MAX_LEN) fail = 1'b1;
          else if (len_new == 16'd0)     state_d = S_CHECK;
          else                           state_d = S_DATA_HI;
        end
        S_DATA_HI: begin
          hi_d    = i_rx_data;
          acc_d   = acc_q ^ i_rx_data;
          state_d = S_DATA_LO;
        end
        S_DATA_LO: begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q[ADDR_WIDTH-1:0];
          wr_data_d = {hi_q, i_rx_data};
          acc_d     = acc_q ^ i_rx_data;
          idx_d     = idx_inc;
          state_d   = (17'(idx_inc) == {1'b0, len_q}) ? S_CHECK : S_DATA_HI;
        end
        S_CHECK: begin
          if (i_rx_data == acc_q) begin
            done_d  = 1'b1;
            hold_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            fail = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Inter-byte watchdog, only armed inside a frame.
    if (state_q == S_IDLE || i_rx_valid) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_inc;
      if (tmo_inc == CW'(TIMEOUT_CYCLES)) fail = 1'b1;
    end

    if (fail) begin
      error_d = 1'b1;
      state_d = S_IDLE;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      hi_q      <= '0;
      acc_q     <= '0;
      tmo_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hold_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      hi_q      <= hi_d;
      acc_q     <= acc_d;
      tmo_q     <= tmo_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign o_wr_en    = wr_en_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_cpu_hold = hold_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_error    = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table of framed byte streams plus hand-written
// timeout, max-length and mid-frame reset sequences; RAM writes go through a scoreboard.
module tb_program_loader;

  localparam int AW  = 8;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          cpu_hold, busy, done, error;

  program_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_reset(rst), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_cpu_hold(cpu_hold), .o_busy(busy), .o_done(done), .o_error(error)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed { logic [AW-1:0] addr; logic [15:0] data; } wr_t;
  typedef struct {
    string       name;
    int          n;
    logic [79:0] bytes;   // left-aligned, first byte in the top bits
    bit          e_done;
    bit          e_err;
    bit          e_hold;
  } vec_t;

  wr_t exp_q[$];
  int  pass_cnt = 0;
  int  total_cnt = 0;
  int  done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Write monitor / scoreboard consumer, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {8'h0, wr_addr, wr_data}, 32'h0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e.addr));
          check("wr_data", 32'(wr_data), 32'(e.data));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // Drives bytes back-to-back; an independent frame parser pushes expected writes.
  task automatic run_frame(input string name, input byte_q_t q,
                           input bit e_done, input bit e_err, input bit e_hold);
    bit          in_f = 1'b0;
    int          pos = 0;
    int          k;
    logic [15:0] len = '0;
    logic [7:0]  hi = '0;
    done_cnt = 0;
    foreach (q[i]) begin
      if (!in_f) begin
        if (q[i] == 8'hA5) begin in_f = 1'b1; pos = 0; end
      end else begin
        pos++;
        if (pos == 1) len[15:8] = q[i];
        else if (pos == 2) len[7:0] = q[i];
        else if (int'(len) <= (1 << AW)) begin
          k = (pos - 3) / 2;
          if (k < int'(len)) begin
            if ((pos - 3) % 2 == 0) hi = q[i];
            else exp_q.push_back('{addr: AW'(k), data: {hi, q[i]}});
          end
        end
      end
      send_byte(q[i]);
      if (in_f && pos == 0 && i != q.size() - 1) check({name, "_busy_in_frame"}, 32'(busy), 32'd1);
    end
    check({name, "_done"},  32'(done),     32'(e_done));
    check({name, "_error"}, 32'(error),    32'(e_err));
    check({name, "_hold"},  32'(cpu_hold), 32'(e_hold));
    check({name, "_busy"},  32'(busy),     32'd0);
    @(posedge clk); #1;
    check({name, "_done_pulse_end"}, 32'(done), 32'd0);
    check({name, "_done_count"}, 32'(done_cnt), 32'(e_done));
    check({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_wr_en"},   32'(wr_en),    32'd0);
    check({name, "_wr_addr"}, 32'(wr_addr),  32'd0);
    check({name, "_wr_data"}, 32'(wr_data),  32'd0);
    check({name, "_hold"},    32'(cpu_hold), 32'd0);
    check({name, "_busy"},    32'(busy),     32'd0);
    check({name, "_done"},    32'(done),     32'd0);
    check({name, "_error"},   32'(error),    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t    vecs[6];
    byte_q_t q;
    logic [7:0] chk, h, l;

    vecs[0] = '{"noise_good", 10, 80'h1122_A500_0212_34AB_CD42, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{"bad_chk",     8, 80'hA500_0212_34AB_CD43_0000, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{"recover",     8, 80'hA500_0212_34AB_CD42_0000, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{"len_ovf",     3, 80'hA501_0100_0000_0000_0000, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{"zero_len",    4, 80'hA500_0000_0000_0000_0000, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{"a5_as_data",  6, 80'hA500_01A5_A501_0000_0000, 1'b1, 1'b0, 1'b0};

    #12;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      q = {};
      for (int j = 0; j < vecs[i].n; j++) q.push_back(vecs[i].bytes[79 - 8*j -: 8]);
      run_frame(vecs[i].name, q, vecs[i].e_done, vecs[i].e_err, vecs[i].e_hold);
    end

    // Largest legal image: 256 words fill addresses 0..255.
    q = {8'hA5, 8'h01, 8'h00};
    chk = 8'h01;
    for (int i = 0; i < 256; i++) begin
      h = 8'(i) ^ 8'h3C;
      l = ~8'(i);
      q.push_back(h);
      q.push_back(l);
      chk = chk ^ h ^ l;
    end
    q.push_back(chk);
    run_frame("len256", q, 1'b1, 1'b0, 1'b0);

    // Timeout: high byte of the only word, then silence.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);
    repeat (15) @(posedge clk);
    #1;
    check("tmo_before", 32'(error), 32'd0);
    check("tmo_busy_before", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("tmo_error", 32'(error), 32'd1);
    check("tmo_hold", 32'(cpu_hold), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_writes_left", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of a frame, then a clean reload.
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    q = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    run_frame("after_reset", q, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Streams a program image from a byte source (UART receiver) into the instruction RAM that the program counter reads. It sits between the serial receiver and the instruction RAM write port, and holds the CPU in reset while a load is in progress. It parses a framed, checksummed packet, assembles big-endian 16-bit words and issues one RAM write per word. It reports completion or failure to the rest of the system.

## Interface
- ADDR_WIDTH, 8: instruction RAM address width. Must equal the program counter/RAM ADDR_WIDTH.
- TIMEOUT_CYCLES, 100000: idle clocks allowed between bytes inside a frame. Counter width is $clog2(TIMEOUT_CYCLES+1).
- i_clk  input  1  system clock; all logic on posedge.
- i_reset  input  1  asynchronous, active-high reset.
- i_rx_valid  input  1  single-cycle strobe; i_rx_data valid this cycle. May be high on consecutive cycles.
- i_rx_data  input  8  received byte.
- o_wr_en  output  1  RAM write strobe, one cycle per word.
- o_wr_addr  output  ADDR_WIDTH  RAM write address.
- o_wr_data  output  16  RAM write data.
- o_cpu_hold  output  1  high = CPU held in reset.
- o_busy  output  1  high while not in IDLE.
- o_done  output  1  one-cycle pulse on successful load.
- o_error  output  1  sticky failure flag.

## Operation
- Frame format: 0xA5, LEN_HI, LEN_LO, then LEN words, each sent as high byte then low byte, then CHK.
  - LEN is a 16-bit word count.
  - CHK is the XOR of every byte after 0xA5, including both length bytes and all data bytes.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK.
- IDLE:
  - Any byte other than 0xA5 is ignored.
  - 0xA5 moves to LEN_HI. It also sets o_cpu_hold, clears o_error, zeroes the XOR accumulator and zeroes the word index.
- LEN_HI: latches the byte and moves to LEN_LO.
- LEN_LO: latches the byte.
  - If LEN > 2^ADDR_WIDTH: error.
  - Else if LEN == 0: move to CHECK.
  - Else: move to DATA_HI.
- DATA_HI: latches the byte and moves to DATA_LO.
- DATA_LO: issues a write of {hi, lo} to address = word index, then increments the index.
  - If the new index == LEN: move to CHECK.
  - Else: move to DATA_HI.
- CHECK:
  - If the byte == accumulator: pulse o_done, clear o_cpu_hold, return to IDLE.
  - Otherwise: error.
- Error action: set o_error, return to IDLE, and keep o_cpu_hold high. Hold stays high until a later successful load or reset.
- Inside a frame, 0xA5 is ordinary data. The block does not resynchronise on it.
- Timeout: in any non-IDLE state, the counter resets on every i_rx_valid and increments otherwise. When it reaches TIMEOUT_CYCLES, error.
- Async reset at any point, including mid-frame, forces IDLE and all outputs to their reset values. The CPU is therefore released even if RAM is partially written; this is accepted.

## Timing
- Reset values:
  - o_wr_en=0, o_wr_addr=0, o_wr_data=0.
  - o_cpu_hold=0, o_busy=0, o_done=0, o_error=0.
- All outputs are registered.
- A byte accepted in cycle N takes effect (state, flags) in cycle N+1.
- Writes:
  - For a low-byte strobe in cycle N, o_wr_en is high in cycle N+1 only, with o_wr_addr and o_wr_data valid in that same cycle.
  - o_wr_addr and o_wr_data hold their last values when o_wr_en=0.
- Back-to-back strobes (every cycle) must be accepted with no byte lost. The maximum write rate is therefore one write per two cycles.
- For a CHK strobe in cycle N: o_done=1 in N+1 only, and o_cpu_hold=0 from N+1.
- o_error rises in cycle N+1 after:
  - the failing byte, or
  - the cycle in which the timeout counter reaches TIMEOUT_CYCLES.
- o_busy=1 from the cycle after 0xA5 until the cycle after the frame ends (done or error).
- Address arithmetic:
  - The index is ADDR_WIDTH+1 bits wide so that LEN == 2^ADDR_WIDTH is representable.
  - o_wr_addr is the low ADDR_WIDTH bits of the index; the last write is to address 2^ADDR_WIDTH-1.

## Test plan
- Noise, then a good frame: send 0x11, 0x22, A5 00 02 12 34 AB CD 42. Required: writes addr0=0x1234 and addr1=0xABCD, o_done pulse once, o_cpu_hold falls, o_error=0, noise produces no writes.
- Bad checksum: send A5 00 02 12 34 AB CD 43. Required: both writes occur, o_error=1, no o_done, o_cpu_hold stays 1. A following good frame then clears o_error and drops hold.
- Length overflow (ADDR_WIDTH=8): send A5 01 01. Required: o_error=1 the cycle after the 0x01 low byte, zero writes, back in IDLE. With A5 01 00, 256 writes occur to addresses 0..255.
- Timeout (TIMEOUT_CYCLES=16): send A5 00 01 12, then silence. Required: o_error rises exactly after 16 idle cycles, with no write.
- Zero length, back-to-back: send A5 00 00 00 on consecutive cycles. Required: no writes, o_done pulse, hold released.
- Reset mid-frame: assert i_reset after the 0x12 byte of frame 1. Required: all outputs return to reset values asynchronously, and the next full good frame loads correctly.
